// File: rtl/wb_retire_queue.sv
`default_nettype none
// ============================================================================
// Module  : wb_retire_queue
// Purpose : In-order write-back retire queue with byte-strobed writes and
//           two youngest-match forwarding lookups for the ID stage.
// Revision: 1.0 - initial release
// ============================================================================
module wb_retire_queue #(
    parameter  int DATA_WIDTH     = 32,
    parameter  int REG_ADDR_WIDTH = 5,
    parameter  int PC_WIDTH       = 32,
    parameter  int DEPTH          = 4,
    localparam int BYTE_LANES     = DATA_WIDTH / 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PC_WIDTH-1:0]       in_pc,
    input  logic [BYTE_LANES-1:0]     in_strobe,
    input  logic [REG_ADDR_WIDTH-1:0] in_waddr,
    input  logic [DATA_WIDTH-1:0]     in_wdata,
    input  logic                      rf_ready,
    output logic [BYTE_LANES-1:0]     rf_we,
    output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0]     rf_wdata,
    input  logic [REG_ADDR_WIDTH-1:0] query_addr0,
    input  logic [REG_ADDR_WIDTH-1:0] query_addr1,
    output logic                      query_hit0,
    output logic                      query_hit1,
    output logic                      query_full0,
    output logic                      query_full1,
    output logic [DATA_WIDTH-1:0]     query_data0,
    output logic [DATA_WIDTH-1:0]     query_data1,
    output logic [PC_WIDTH-1:0]       debug_pc,
    output logic [BYTE_LANES-1:0]     debug_we,
    output logic [REG_ADDR_WIDTH-1:0] debug_waddr,
    output logic [DATA_WIDTH-1:0]     debug_wdata
);

    localparam int                 c_ptr_w   = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]   c_depth   = DEPTH[c_ptr_w:0];
    localparam logic [c_ptr_w-1:0] c_ptr_one = 1;
    localparam logic [c_ptr_w:0]   c_cnt_one = 1;

    logic [PC_WIDTH-1:0]       r_pc     [DEPTH];
    logic [BYTE_LANES-1:0]     r_strobe [DEPTH];
    logic [REG_ADDR_WIDTH-1:0] r_waddr  [DEPTH];
    logic [DATA_WIDTH-1:0]     r_wdata  [DEPTH];

    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_ptr_w:0]   r_count;

    logic w_head_valid;
    logic w_retire;
    logic w_enq;

    assign w_head_valid = (r_count != '0);
    assign w_retire     = w_head_valid && rf_ready;
    // A full queue still accepts when the head leaves in the same cycle.
    assign in_ready     = (r_count < c_depth) || w_retire;
    assign w_enq        = in_valid && in_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + c_ptr_one;
            end
            if (w_retire) begin
                r_head <= r_head + c_ptr_one;
            end
            case ({w_enq, w_retire})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage is never cleared; validity comes from head/count only.
    always_ff @(posedge clock) begin
        if (w_enq) begin
            r_pc[r_tail]     <= in_pc;
            r_strobe[r_tail] <= in_strobe;
            r_waddr[r_tail]  <= in_waddr;
            r_wdata[r_tail]  <= in_wdata;
        end
    end

    always_comb begin
        rf_we    = '0;
        rf_waddr = '0;
        rf_wdata = '0;
        debug_pc = '0;
        if (w_head_valid) begin
            rf_waddr = r_waddr[r_head];
            rf_wdata = r_wdata[r_head];
            debug_pc = r_pc[r_head];
            if (r_waddr[r_head] != '0) begin
                rf_we = r_strobe[r_head];
            end
        end
    end

    assign debug_we    = rf_we;
    assign debug_waddr = rf_waddr;
    assign debug_wdata = rf_wdata;

    function automatic logic f_match(input logic [c_ptr_w-1:0]       idx,
                                     input logic [REG_ADDR_WIDTH-1:0] addr);
        return (r_waddr[idx] == addr) && (r_waddr[idx] != '0) && (r_strobe[idx] != '0);
    endfunction

    // Walk from head to tail so that the youngest match overwrites older ones.
    always_comb begin
        logic [c_ptr_w-1:0] v_idx;
        query_hit0  = 1'b0;
        query_hit1  = 1'b0;
        query_full0 = 1'b0;
        query_full1 = 1'b0;
        query_data0 = '0;
        query_data1 = '0;
        v_idx       = '0;
        for (int k = 0; k < DEPTH; k++) begin
            v_idx = r_head + k[c_ptr_w-1:0];
            if (k[c_ptr_w:0] < r_count) begin
                if (f_match(v_idx, query_addr0)) begin
                    query_hit0  = 1'b1;
                    query_full0 = &r_strobe[v_idx];
                    query_data0 = r_wdata[v_idx];
                end
                if (f_match(v_idx, query_addr1)) begin
                    query_hit1  = 1'b1;
                    query_full1 = &r_strobe[v_idx];
                    query_data1 = r_wdata[v_idx];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_retire_queue.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_retire_queue
// Purpose : Scoreboard bench for wb_retire_queue with a queue-based model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_wb_retire_queue;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int PW    = 32;
    localparam int DEPTH = 4;
    localparam int BL    = DW / 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_pc;
    logic [BL-1:0] in_strobe;
    logic [AW-1:0] in_waddr;
    logic [DW-1:0] in_wdata;
    logic          rf_ready;
    logic [BL-1:0] rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [AW-1:0] query_addr0, query_addr1;
    logic          query_hit0, query_hit1, query_full0, query_full1;
    logic [DW-1:0] query_data0, query_data1;
    logic [PW-1:0] debug_pc;
    logic [BL-1:0] debug_we;
    logic [AW-1:0] debug_waddr;
    logic [DW-1:0] debug_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    wb_retire_queue #(
        .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .PC_WIDTH(PW), .DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_strobe(in_strobe), .in_waddr(in_waddr), .in_wdata(in_wdata),
        .rf_ready(rf_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .query_addr0(query_addr0), .query_addr1(query_addr1),
        .query_hit0(query_hit0), .query_hit1(query_hit1),
        .query_full0(query_full0), .query_full1(query_full1),
        .query_data0(query_data0), .query_data1(query_data1),
        .debug_pc(debug_pc), .debug_we(debug_we),
        .debug_waddr(debug_waddr), .debug_wdata(debug_wdata)
    );

    typedef struct {
        logic [PW-1:0] pc;
        logic [BL-1:0] strobe;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
    } ent_t;

    ent_t mq[$];
    bit   model_ok = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Youngest in-flight entry writing the register wins.
    task automatic ref_query(input logic [AW-1:0] a, output logic hit, output logic full,
                             output logic [DW-1:0] data);
        hit = 1'b0; full = 1'b0; data = '0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].waddr == a && a != 0 && mq[i].strobe != 0) begin
                hit  = 1'b1;
                full = (mq[i].strobe == {BL{1'b1}});
                data = mq[i].wdata;
                return;
            end
        end
    endtask

    // Scoreboard update: accepted stimulus is pushed, retired head is popped.
    always @(posedge clock) begin
        bit acc, ret;
        if (reset) begin
            mq.delete();
            model_ok = 1'b1;
        end else if (model_ok) begin
            ret = (mq.size() > 0) && rf_ready;
            acc = in_valid && ((mq.size() < DEPTH) || ret);
            if (ret) void'(mq.pop_front());
            if (acc) mq.push_back('{in_pc, in_strobe, in_waddr, in_wdata});
        end
    end

    // Monitor: compare every presented output against the model on the falling edge.
    always @(negedge clock) begin
        logic [BL-1:0] e_we;
        logic [AW-1:0] e_wa;
        logic [DW-1:0] e_wd;
        logic [PW-1:0] e_pc;
        logic          e_h0, e_f0, e_h1, e_f1;
        logic [DW-1:0] e_d0, e_d1;
        if (model_ok) begin
            e_we = '0; e_wa = '0; e_wd = '0; e_pc = '0;
            if (mq.size() > 0) begin
                e_wa = mq[0].waddr;
                e_wd = mq[0].wdata;
                e_pc = mq[0].pc;
                e_we = (mq[0].waddr != 0) ? mq[0].strobe : '0;
            end
            chk("in_ready", in_ready, (mq.size() < DEPTH) || (mq.size() > 0 && rf_ready));
            chk("rf_we", rf_we, e_we);
            chk("rf_waddr", rf_waddr, e_wa);
            chk("rf_wdata", rf_wdata, e_wd);
            chk("debug_pc", debug_pc, e_pc);
            chk("debug_we", debug_we, e_we);
            chk("debug_waddr", debug_waddr, e_wa);
            chk("debug_wdata", debug_wdata, e_wd);
            ref_query(query_addr0, e_h0, e_f0, e_d0);
            ref_query(query_addr1, e_h1, e_f1, e_d1);
            chk("query0", {query_hit0, query_full0, query_data0}, {e_h0, e_f0, e_d0});
            chk("query1", {query_hit1, query_full1, query_data1}, {e_h1, e_f1, e_d1});
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic put(input logic v, input logic [PW-1:0] pc, input logic [BL-1:0] s,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
        in_valid = v; in_pc = pc; in_strobe = s; in_waddr = a; in_wdata = d;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; rf_ready = 1'b0; query_addr0 = '0; query_addr1 = '0;
        put(1'b0, '0, '0, '0, '0);
        step(); step();
        reset = 1'b0;
        #1;
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_rf_we", rf_we, '0);

        // Single write, one-cycle latency.
        rf_ready = 1'b1;
        put(1'b1, 32'hBFC0_0000, 4'hF, 5'd8, 32'h1234_5678);
        step();
        put(1'b0, '0, '0, '0, '0);
        #1;
        chk("t1_we", rf_we, 4'hF);
        chk("t1_waddr", rf_waddr, 5'd8);
        chk("t1_pc", debug_pc, 32'hBFC0_0000);
        step();
        chk("t1_we_after", rf_we, 4'h0);

        // Backpressure fill and full-plus-retire acceptance.
        rf_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            put(1'b1, 32'(i * 4), 4'hF, 5'(i + 1), $urandom);
            step();
        end
        put(1'b1, 32'd16, 4'hF, 5'd5, $urandom);
        #1;
        chk("t2_full_not_ready", in_ready, 1'b0);
        chk("t2_head_pc", debug_pc, 32'd0);
        rf_ready = 1'b1;
        #1;
        chk("t2_full_retire_ready", in_ready, 1'b1);
        step();
        put(1'b0, '0, '0, '0, '0);
        repeat (DEPTH + 1) step();

        // Forwarding priority: youngest partial write shadows older full write.
        rf_ready = 1'b0;
        query_addr0 = 5'd3;
        put(1'b1, 32'h40, 4'hF, 5'd3, 32'hAAAA_0000);
        step();
        put(1'b1, 32'h44, 4'b0001, 5'd3, 32'h0000_00BB);
        step();
        put(1'b0, '0, '0, '0, '0);
        #1;
        chk("t3_fwd", {query_hit0, query_full0, query_data0}, {1'b1, 1'b0, 32'h0000_00BB});
        rf_ready = 1'b1;
        step();
        rf_ready = 1'b0;
        #1;
        chk("t3_fwd_one_left", {query_hit0, query_full0, query_data0}, {1'b1, 1'b0, 32'h0000_00BB});
        rf_ready = 1'b1;
        step();
        chk("t3_fwd_empty", query_hit0, 1'b0);

        // Writes to $0 and zero-strobe writes retire silently.
        query_addr0 = 5'd0; query_addr1 = 5'd5;
        put(1'b1, 32'h100, 4'hF, 5'd0, 32'hDEAD_BEEF);
        step();
        put(1'b1, 32'h104, 4'h0, 5'd5, 32'hCAFE_F00D);
        #1;
        chk("t4_zero_we", rf_we, 4'h0);
        chk("t4_zero_pc", debug_pc, 32'h100);
        step();
        put(1'b0, '0, '0, '0, '0);
        #1;
        chk("t4_null_we", rf_we, 4'h0);
        chk("t4_null_pc", debug_pc, 32'h104);
        chk("t4_null_hit", query_hit1, 1'b0);
        step();

        // Randomised streaming across many pointer wraps.
        for (int c = 0; c < 400; c++) begin
            int sel;
            logic [BL-1:0] s;
            sel = int'($urandom_range(0, 5));
            s = (sel == 0) ? 4'h0 : (sel <= 3) ? 4'hF : BL'($urandom);
            put($urandom_range(0, 3) != 0, 32'h1000 + 32'(c * 4), s,
                AW'($urandom_range(0, 7)), $urandom);
            rf_ready    = $urandom_range(0, 2) != 0;
            query_addr0 = AW'($urandom_range(0, 7));
            query_addr1 = AW'($urandom_range(0, 7));
            step();
        end
        put(1'b0, '0, '0, '0, '0);
        rf_ready = 1'b1;
        repeat (DEPTH + 1) step();

        // Reset in the middle of operation discards queued entries.
        rf_ready = 1'b0;
        query_addr0 = 5'd9;
        for (int i = 0; i < 3; i++) begin
            put(1'b1, 32'h200 + 32'(i * 4), 4'hF, 5'(9 + i), $urandom);
            step();
        end
        put(1'b0, '0, '0, '0, '0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("t6_in_ready", in_ready, 1'b1);
        chk("t6_rf_we", rf_we, 4'h0);
        chk("t6_hit", query_hit0, 1'b0);
        rf_ready = 1'b1;
        put(1'b1, 32'h300, 4'hF, 5'd12, 32'h0BAD_F00D);
        step();
        put(1'b0, '0, '0, '0, '0);
        #1;
        chk("t6_new_waddr", rf_waddr, 5'd12);
        chk("t6_new_wdata", rf_wdata, 32'h0BAD_F00D);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
